mux_gen_pipe: RTL

- Parametrised, pipelined N-way selector for the mode datapath; generalises the combinational recursive mux tree.
- Selects one of N entries of BUS_DATA_SIZE bits with a radix-2 tree, registering every LEVELS_PER_STAGE tree levels.
- Carries select bits, valid and error flag through the pipeline under a valid/ready handshake.
- Adds out-of-range select detection, zero-gated output when idle, and synchronous flush.

---
 rtl/mux_gen_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mux_gen_pipe.sv
// Pipelined N-way radix-2 selector with elastic valid/ready stages.
// Flags out-of-range selects, gates data_out to zero when idle, supports synchronous flush.
module mux_gen_pipe #(
    parameter int N                = 7,
    parameter int BUS_DATA_SIZE    = 1,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int log2N            = (N > 1) ? $clog2(N) : 1,
    parameter int STAGES           = (log2N + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N*BUS_DATA_SIZE-1:0] data_in,
    input  logic [log2N-1:0]           ctrl,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic [BUS_DATA_SIZE-1:0]   data_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic                       sel_err
);

    localparam int B    = BUS_DATA_SIZE;
    localparam int PAD  = 1 << log2N;
    localparam int LAST = STAGES - 1;
    localparam logic [log2N:0] N_VEC = (log2N + 1)'(N);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_err;
    logic              accept;
    logic              err_in;
    logic              full;
    logic [PAD*B-1:0]  padded;

    always_comb begin
        padded            = '0;
        padded[N*B-1:0]   = data_in;
    end

    assign err_in   = ({1'b0, ctrl} >= N_VEC);
    assign ready_in = load[0] & ~flush & ~rst;
    assign accept   = valid_in & ready_in;

    // load[s] = ~v[s] | load[s+1] unrolled: a stage may load unless it and
    // every stage downstream are occupied while the sink stalls.
    always_comb begin
        load = '0;
        full = 1'b1;
        for (int unsigned s = 0; s < STAGES; s++) begin
            full = 1'b1;
            for (int unsigned t = s; t < STAGES; t++)
                full = full & valid_q[t];
            load[s] = ready_out | ~full;
        end
    end

    always_comb begin
        up_valid    = '0;
        up_err      = '0;
        up_valid[0] = accept;
        up_err[0]   = err_in;
        for (int unsigned s = 1; s < STAGES; s++) begin
            up_valid[s] = valid_q[s-1];
            up_err[s]   = err_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++)
                if (load[s]) valid_q[s] <= up_valid[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++)
                if (load[s] & up_valid[s]) err_q[s] <= up_err[s];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : stage
        localparam int LO   = s * LEVELS_PER_STAGE;
        localparam int HI   = (LO + LEVELS_PER_STAGE < log2N) ? LO + LEVELS_PER_STAGE : log2N;
        localparam int NLEV = HI - LO;
        localparam int EIN  = 1 << (log2N - LO);
        localparam int EOUT = 1 << (log2N - HI);
        localparam int CIN  = log2N - LO;
        localparam int COUT = log2N - HI;

        logic [EIN*B-1:0]  din;
        logic [CIN-1:0]    cin;
        logic [EIN*B-1:0]  work;
        logic [EOUT*B-1:0] data_q;

        if (s == 0) begin : g_src
            assign din = padded;
            assign cin = ctrl;
        end else begin : g_src
            assign din = stage[s-1].data_q;
            assign cin = stage[s-1].g_ctrl.ctrl_q;
        end

        // In-place reduction: entry j is rewritten only after entries 2j/2j+1 were read.
        always_comb begin
            work = din;
            for (int unsigned l = 0; l < NLEV; l++)
                for (int unsigned j = 0; j < (EIN >> (l + 1)); j++)
                    work[j*B +: B] = cin[l] ? work[(2*j+1)*B +: B] : work[(2*j)*B +: B];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                data_q <= '0;
            else if (load[s] & up_valid[s])
                data_q <= work[EOUT*B-1:0];
        end

        if (COUT > 0) begin : g_ctrl
            logic [COUT-1:0] ctrl_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    ctrl_q <= '0;
                else if (load[s] & up_valid[s])
                    ctrl_q <= cin[CIN-1:NLEV];
            end
        end
    end

    assign valid_out = valid_q[LAST];
    assign sel_err   = valid_q[LAST] & err_q[LAST];
    assign data_out  = (valid_out & ~sel_err) ? stage[LAST].data_q : '0;

endmodule
